lcd_bus_monitor: RTL and testbench
==================================

LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; every flop updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port lcd_rs, input, 1 bit: register select, 0 = command, 1 = data.
REQ-004 The block SHALL have the port lcd_rw, input, 1 bit: 0 = write, 1 = read.
REQ-005 The block SHALL have the port lcd_e, input, 1 bit: enable strobe; a transfer completes on its falling edge.
REQ-006 The block SHALL have the port lcd_data, input, 8 bits: bus byte.
REQ-007 The block SHALL have the port line1_data, output, 128 bits: row 0 text; character position p occupies bits [8p+7:8p], p = 0..15 left to right.
REQ-008 The block SHALL have the port line2_data, output, 128 bits: row 1 text, packed the same way as line1_data.
REQ-009 The block SHALL have the port display_on, output, 1 bit: the D bit from the last display-control command.
REQ-010 The block SHALL have the port addr, output, 7 bits: the current DDRAM address counter.
REQ-011 The block SHALL have the port char_wr, output, 1 bit: a one-cycle pulse when a visible character cell is written.

Function
REQ-012 The block SHALL pass lcd_rs, lcd_rw, lcd_e and lcd_data through a 2-flop synchronizer, then through a third register stage.
REQ-013 A transfer SHALL be detected when stage 2 lcd_e = 0 and stage 3 lcd_e = 1.
REQ-014 The rs, rw and data values of a detected transfer SHALL be taken from stage 3.
REQ-015 Latency: let edge 0 be the first rising clk edge that samples lcd_e low; all state and outputs for that transfer SHALL update at edge 2.
REQ-016 Strobe pulses SHALL be at least 2 clk high and 2 clk low; no behaviour is required for shorter pulses.
REQ-017 Transfers with rw = 1 SHALL change no state; the busy flag is not modelled.
REQ-018 Command decode (rs = 0) SHALL use the highest set bit of the byte, as follows:
- 0x01 clear: all 32 cells = 0x20, addr = 0x00, I/D = 1, mode = DDRAM.
- 0x02/0x03 return home: addr = 0x00, mode = DDRAM; cells unchanged.
- 0x04-0x07 entry mode: I/D = bit1; the shift bit (bit0) is ignored.
- 0x08-0x0F display control: display_on = bit2; cursor and blink bits are ignored.
- 0x10-0x1F shift: if bit3 = 0 (cursor move), addr is incremented when bit2 = 1 and decremented when bit2 = 0; if bit3 = 1 (display shift), no effect.
- 0x20-0x3F function set: no effect.
- 0x40-0x7F CGRAM address: mode = CGRAM.
- 0x80-0xFF DDRAM address: addr = data[6:0], mode = DDRAM.
- 0x00: no effect.
REQ-019 A data write (rs = 1, rw = 0) in DDRAM mode SHALL store the byte to the cell selected by addr, then step addr by I/D.
REQ-020 A data write in CGRAM mode SHALL discard the byte and leave addr unchanged.
REQ-021 Cell mapping SHALL be: addr 0x00-0x0F = line1 position addr; addr 0x40-0x4F = line2 position addr-0x40.
REQ-022 For any other addr, a data write SHALL store nothing and give no char_wr pulse, but SHALL still step addr.
REQ-023 Address step on increment SHALL be: 0x27 -> 0x40; 0x67 -> 0x00; otherwise +1.
REQ-024 Address step on decrement SHALL be: 0x00 -> 0x67; 0x40 -> 0x27; otherwise -1.
REQ-025 A DDRAM address command with a value in 0x28-0x3F or 0x68-0x7F SHALL be loaded unchanged; the next increment SHALL give +1 except 0x7F -> 0x00, and the next decrement SHALL give -1.
REQ-026 char_wr SHALL be high for exactly the single cycle in which a visible cell changes (edge 2 to edge 3).
REQ-027 Back-to-back transfers SHALL each be processed in order; none SHALL be lost if the strobe timing in REQ-016 is met.

Reset
REQ-028 While rst = 1 at a clk edge, the following SHALL be set: all 32 cells = 0x20, addr = 0x00, I/D = 1, mode = DDRAM, display_on = 0, char_wr = 0, all synchronizer stages = 0.
REQ-029 Reset asserted during a strobe SHALL abandon that transfer.
REQ-030 An lcd_e that is already high when rst is released SHALL NOT produce a transfer until it has been observed high after reset and then falls.
REQ-031 Reset SHALL take priority over a transfer detected in the same cycle.

Verification
REQ-032 Reset, then write 0x80 followed by data 0x48, 0x49 -> line1 bits [15:0] = 0x4948; addr = 0x02; two char_wr pulses, each at edge 2 of its strobe.
REQ-033 Write 0xCF then data 0x41, 0x42 -> line2 bits [127:120] = 0x41; addr = 0x50 after the first write; the second write leaves the buffers unchanged, gives no char_wr, and addr = 0x51.
REQ-034 Write 0xA7 then one data byte -> addr = 0x40, no cell changes. Then write 0x04, 0xC0 and one data byte -> line2 pos 0 written; addr = 0x27.
REQ-035 Write 0x0C -> display_on = 1; then 0x08 -> 0; then fill cells and write 0x01 -> all cells = 0x20, addr = 0x00.
REQ-036 Write 0x40 then data 0x1F -> no cell changes, addr unchanged; then write 0x80 and data 0x30 -> line1 pos 0 = 0x30.
REQ-037 Assert rst while lcd_e is high mid-strobe, release it, then let lcd_e fall -> no write occurs and all outputs remain at their reset values.

Source files
------------

// File: rtl/lcd_bus_monitor.sv
// rtl/lcd_bus_monitor.sv - passive HD44780-style bus snooper that mirrors the visible 2x16 text
module lcd_bus_monitor (
  input  logic         clk,
  input  logic         rst,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic         lcd_e,
  input  logic [7:0]   lcd_data,
  output logic [127:0] line1_data,
  output logic [127:0] line2_data,
  output logic         display_on,
  output logic [6:0]   addr,
  output logic         char_wr
);

  typedef enum logic {
    MODE_DDRAM = 1'b0,
    MODE_CGRAM = 1'b1
  } mode_t;

  localparam logic [127:0] BLANK_LINE = {16{8'h20}};

  // Synchronizer stages 1/2 tame metastability, stage 3 gives the edge reference.
  logic       e_s1, e_s2, e_s3;
  logic       rs_s1, rs_s2, rs_s3;
  logic       rw_s1, rw_s2, rw_s3;
  logic [7:0] data_s1, data_s2, data_s3;

  // Valid bits mark which stages hold real post-reset samples (reset zeros are not samples).
  logic       v1, v2, v3;
  logic       armed;

  mode_t      mode;
  logic       incr;

  logic       xfer;
  logic       cell_visible;
  logic [3:0] cell_pos;
  logic       cell_row;

  // Address counter step on increment: the two 40-cell rows wrap into each other.
  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    logic [6:0] r;
    case (a)
      7'h27:   r = 7'h40;
      7'h67:   r = 7'h00;
      7'h7F:   r = 7'h00;
      default: r = a + 7'd1;
    endcase
    return r;
  endfunction

  // Address counter step on decrement, mirror image of addr_inc.
  function automatic logic [6:0] addr_dec(input logic [6:0] a);
    logic [6:0] r;
    case (a)
      7'h00:   r = 7'h67;
      7'h40:   r = 7'h27;
      default: r = a - 7'd1;
    endcase
    return r;
  endfunction

  // Falling strobe seen between stage 2 and stage 3; only trusted once armed.
  assign xfer = armed && !e_s2 && e_s3;

  // Only the first 16 cells of each row are on screen.
  assign cell_visible = (addr[6:4] == 3'b000) || (addr[6:4] == 3'b100);
  assign cell_pos     = addr[3:0];
  assign cell_row     = addr[6];

  // Three-deep input pipeline for strobe, control and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_s1    <= 1'b0;
      e_s2    <= 1'b0;
      e_s3    <= 1'b0;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      rs_s3   <= 1'b0;
      rw_s1   <= 1'b0;
      rw_s2   <= 1'b0;
      rw_s3   <= 1'b0;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
      data_s3 <= 8'h00;
    end else begin
      e_s1    <= lcd_e;
      e_s2    <= e_s1;
      e_s3    <= e_s2;
      rs_s1   <= lcd_rs;
      rs_s2   <= rs_s1;
      rs_s3   <= rs_s2;
      rw_s1   <= lcd_rw;
      rw_s2   <= rw_s1;
      rw_s3   <= rw_s2;
      data_s1 <= lcd_data;
      data_s2 <= data_s1;
      data_s3 <= data_s2;
    end
  end

  // Arm detection only after a genuine low strobe has reached stage 3, so a strobe
  // already high across reset release cannot complete a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      armed <= 1'b0;
    end else begin
      v1 <= 1'b1;
      v2 <= v1;
      v3 <= v2;
      if (v3 && !e_s3) begin
        armed <= 1'b1;
      end
    end
  end

  // Decode each completed write and update the shadow display state.
  always_ff @(posedge clk) begin
    if (rst) begin
      line1_data <= BLANK_LINE;
      line2_data <= BLANK_LINE;
      addr       <= 7'h00;
      incr       <= 1'b1;
      mode       <= MODE_DDRAM;
      display_on <= 1'b0;
      char_wr    <= 1'b0;
    end else begin
      char_wr <= 1'b0;
      if (xfer && !rw_s3) begin
        if (!rs_s3) begin
          // Commands are identified by their most significant set bit.
          casez (data_s3)
            8'b1???????: begin
              addr <= data_s3[6:0];
              mode <= MODE_DDRAM;
            end
            8'b01??????: begin
              mode <= MODE_CGRAM;
            end
            8'b001?????: begin
              // function set: bus width / lines / font do not affect the mirror
            end
            8'b0001????: begin
              if (!data_s3[3]) begin
                addr <= data_s3[2] ? addr_inc(addr) : addr_dec(addr);
              end
            end
            8'b00001???: begin
              display_on <= data_s3[2];
            end
            8'b000001??: begin
              incr <= data_s3[1];
            end
            8'b0000001?: begin
              addr <= 7'h00;
              mode <= MODE_DDRAM;
            end
            8'b00000001: begin
              line1_data <= BLANK_LINE;
              line2_data <= BLANK_LINE;
              addr       <= 7'h00;
              incr       <= 1'b1;
              mode       <= MODE_DDRAM;
            end
            default: begin
            end
          endcase
        end else if (mode == MODE_DDRAM) begin
          // Off-screen cells are not stored, but the counter still walks over them.
          if (cell_visible) begin
            if (cell_row) begin
              line2_data[{cell_pos, 3'b000} +: 8] <= data_s3;
            end else begin
              line1_data[{cell_pos, 3'b000} +: 8] <= data_s3;
            end
            char_wr <= 1'b1;
          end
          addr <= incr ? addr_inc(addr) : addr_dec(addr);
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// tb/tb_lcd_bus_monitor.sv - directed self-checking bench for lcd_bus_monitor
module tb_lcd_bus_monitor;

  logic         clk;
  logic         rst;
  logic         lcd_rs;
  logic         lcd_rw;
  logic         lcd_e;
  logic [7:0]   lcd_data;
  logic [127:0] line1_data;
  logic [127:0] line2_data;
  logic         display_on;
  logic [6:0]   addr;
  logic         char_wr;

  int checks;
  int failures;
  int cw_seen;

  logic [127:0] exp_l1;
  logic [127:0] exp_l2;

  localparam logic [127:0] BLANK = {16{8'h20}};

  lcd_bus_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_data   (lcd_data),
    .line1_data (line1_data),
    .line2_data (line2_data),
    .display_on (display_on),
    .addr       (addr),
    .char_wr    (char_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus transfer; the strobe falls just after a clock edge so edge 2 is known exactly.
  task automatic bus(input logic rs, input logic rw, input logic [7:0] b, input logic exp_cw);
    lcd_rs   = rs;
    lcd_rw   = rw;
    lcd_data = b;
    lcd_e    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lcd_e = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("char_wr_edge1", {127'd0, char_wr}, 128'd0);
    @(posedge clk);
    #1;
    chk("char_wr_edge2", {127'd0, char_wr}, {127'd0, exp_cw});
    @(posedge clk);
    #1;
    chk("char_wr_edge3", {127'd0, char_wr}, 128'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [6:0] exp_addr);
    chk({tag, "_line1"}, line1_data, exp_l1);
    chk({tag, "_line2"}, line2_data, exp_l2);
    chk({tag, "_addr"}, {121'd0, addr}, {121'd0, exp_addr});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cw_seen  = 0;
    rst      = 1'b1;
    lcd_rs   = 1'b0;
    lcd_rw   = 1'b0;
    lcd_e    = 1'b0;
    lcd_data = 8'h00;
    exp_l1   = BLANK;
    exp_l2   = BLANK;
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 7'h00);
    chk("reset_display_on", {127'd0, display_on}, 128'd0);
    chk("reset_char_wr", {127'd0, char_wr}, 128'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Two characters at the start of line 1
    bus(1'b0, 1'b0, 8'h80, 1'b0);
    bus(1'b1, 1'b0, 8'h48, 1'b1);
    bus(1'b1, 1'b0, 8'h49, 1'b1);
    exp_l1[15:0] = 16'h4948;
    chk_state("hi", 7'h02);

    // Last visible cell of line 2, then an off-screen cell
    bus(1'b0, 1'b0, 8'hCF, 1'b0);
    chk_state("set_4f", 7'h4F);
    bus(1'b1, 1'b0, 8'h41, 1'b1);
    exp_l2[127:120] = 8'h41;
    chk_state("l2_last", 7'h50);
    bus(1'b1, 1'b0, 8'h42, 1'b0);
    chk_state("offscreen", 7'h51);

    // Row wrap on increment, then decrement across the row boundary
    bus(1'b0, 1'b0, 8'hA7, 1'b0);
    bus(1'b1, 1'b0, 8'h55, 1'b0);
    chk_state("wrap_27", 7'h40);
    bus(1'b0, 1'b0, 8'h04, 1'b0);
    bus(1'b0, 1'b0, 8'hC0, 1'b0);
    bus(1'b1, 1'b0, 8'h58, 1'b1);
    exp_l2[7:0] = 8'h58;
    chk_state("dec_40", 7'h27);

    // Cursor / display shift commands
    bus(1'b0, 1'b0, 8'h14, 1'b0);
    chk_state("shift_r", 7'h40);
    bus(1'b0, 1'b0, 8'h10, 1'b0);
    chk_state("shift_l", 7'h27);
    bus(1'b0, 1'b0, 8'h18, 1'b0);
    chk_state("disp_shift", 7'h27);
    bus(1'b0, 1'b0, 8'h06, 1'b0);
    bus(1'b0, 1'b0, 8'hE7, 1'b0);
    bus(1'b0, 1'b0, 8'h14, 1'b0);
    chk_state("inc_67", 7'h00);
    bus(1'b0, 1'b0, 8'h10, 1'b0);
    chk_state("dec_00", 7'h67);

    // Addresses in the gaps load unchanged and step linearly
    bus(1'b0, 1'b0, 8'hFF, 1'b0);
    chk_state("load_7f", 7'h7F);
    bus(1'b0, 1'b0, 8'h14, 1'b0);
    chk_state("inc_7f", 7'h00);
    bus(1'b0, 1'b0, 8'hA8, 1'b0);
    bus(1'b0, 1'b0, 8'h14, 1'b0);
    chk_state("inc_28", 7'h29);
    bus(1'b0, 1'b0, 8'h10, 1'b0);
    chk_state("dec_29", 7'h28);

    // Reads change nothing
    bus(1'b0, 1'b0, 8'h80, 1'b0);
    bus(1'b1, 1'b1, 8'h77, 1'b0);
    chk_state("read", 7'h00);

    // Display control, fill, clear (clear also restores increment)
    bus(1'b0, 1'b0, 8'h0C, 1'b0);
    chk("disp_on", {127'd0, display_on}, {127'd0, 1'b1});
    bus(1'b0, 1'b0, 8'h08, 1'b0);
    chk("disp_off", {127'd0, display_on}, 128'd0);
    bus(1'b1, 1'b0, 8'h5A, 1'b1);
    exp_l1[7:0] = 8'h5A;
    chk_state("fill", 7'h01);
    bus(1'b0, 1'b0, 8'h04, 1'b0);
    bus(1'b0, 1'b0, 8'h01, 1'b0);
    exp_l1 = BLANK;
    exp_l2 = BLANK;
    chk_state("clear", 7'h00);
    bus(1'b1, 1'b0, 8'h31, 1'b1);
    exp_l1[7:0] = 8'h31;
    chk_state("clear_incr", 7'h01);

    // CGRAM data is discarded; DDRAM command returns to text
    bus(1'b0, 1'b0, 8'h40, 1'b0);
    bus(1'b1, 1'b0, 8'h1F, 1'b0);
    chk_state("cgram", 7'h01);
    bus(1'b0, 1'b0, 8'h80, 1'b0);
    bus(1'b1, 1'b0, 8'h30, 1'b1);
    exp_l1[7:0] = 8'h30;
    chk_state("ddram_back", 7'h01);

    // Reset in the middle of a strobe abandons it
    bus(1'b0, 1'b0, 8'h0C, 1'b0);
    lcd_rs   = 1'b1;
    lcd_rw   = 1'b0;
    lcd_data = 8'h44;
    lcd_e    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (char_wr) cw_seen++;
    end
    lcd_e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (char_wr) cw_seen++;
    end
    exp_l1 = BLANK;
    exp_l2 = BLANK;
    chk("rst_strobe_cw", cw_seen, 128'd0);
    chk_state("rst_strobe", 7'h00);
    chk("rst_strobe_disp", {127'd0, display_on}, 128'd0);

    // Monitor still works after that
    bus(1'b1, 1'b0, 8'h41, 1'b1);
    exp_l1[7:0] = 8'h41;
    chk_state("post_rst", 7'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
